// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding,
// default byte width and bit positions of the packed UART status word.
package uart_pkg;

   localparam int UART_DW = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      START = 3'd2,
      XFER  = 3'd3,
      FIN   = 3'd4
   } sched_state_t;

   // Bit positions inside the packed {idle, error, done, busy} status word
   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;
   localparam int STAT_ERROR = 2;
   localparam int STAT_IDLE  = 3;
   localparam int STAT_W     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: returns the first set request at or above ptr,
// wrapping from NREQ-1 back to 0. Purely combinational.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      ptr,
   output logic [NREQ-1:0] onehot,
   output logic [2:0]      index,
   output logic            valid
);

   logic [NREQ-1:0] rot;
   logic [2:0]      off;
   int              pos;

   // Rotate requests so ptr sits at bit 0, find the lowest set bit, rotate back
   always_comb begin
      rot = NREQ'({req, req} >> ptr);
      off = 3'd0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) off = 3'(k);
      end
      pos = int'(ptr) + int'(off);
      if (pos >= NREQ) pos = pos - NREQ;
      index  = 3'(pos);
      valid  = |req;
      onehot = valid ? ({{(NREQ-1){1'b0}}, 1'b1} << index) : '0;
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ clients,
// with per-client grant/done/error pulses and a start timeout.
import uart_pkg::*;

module uart_tx_sched #(
   parameter int NREQ = 4,
   parameter int DW   = UART_DW,
   parameter int TMO  = 32
) (
   input  logic               clka,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [NREQ-1:0]    err,
   output logic [DW-1:0]      tx_data,
   output logic               tx_rdy,
   input  logic               tx_busy,
   input  logic               tx_done,
   input  logic               tx_error,
   input  logic               tx_idle,
   output logic [2:0]         cur_id,
   output logic               sched_busy
);

   localparam int            CW       = $clog2(TMO) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

   sched_state_t      state_reg, state_next;
   logic              err_flag_reg, err_flag_next;
   logic [2:0]        cur_id_reg, ptr_reg, ptr_next;
   logic [NREQ-1:0]   mask_reg;
   logic [DW-1:0]     tx_data_reg;
   logic [CW-1:0]     cnt_reg;
   logic              tmo_reg;
   logic [STAT_W-1:0] status;
   logic [NREQ-1:0]   arb_onehot;
   logic [2:0]        arb_index;
   logic              arb_valid;
   logic [DW-1:0]     slot [8];

   genvar gi;

   assign status[STAT_BUSY]  = tx_busy;
   assign status[STAT_DONE]  = tx_done;
   assign status[STAT_ERROR] = tx_error;
   assign status[STAT_IDLE]  = tx_idle;

   // Byte lanes padded to 8 so the 3-bit cur_id indexes them without truncation
   generate
      for (gi = 0; gi < 8; gi++) begin : g_slot
         if (gi < NREQ) begin : g_used
            assign slot[gi] = req_data[gi*DW +: DW];
         end else begin : g_pad
            assign slot[gi] = '0;
         end
      end
   endgenerate

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .ptr    (ptr_reg),
      .onehot (arb_onehot),
      .index  (arb_index),
      .valid  (arb_valid)
   );

   assign ptr_next = (cur_id_reg == 3'(NREQ - 1)) ? 3'd0 : cur_id_reg + 3'd1;

   // Next-state logic; tx_error outranks tx_busy/tx_done and the timeout
   always_comb begin
      state_next    = state_reg;
      err_flag_next = err_flag_reg;
      case (state_reg)
         IDLE: begin
            if (arb_valid && status[STAT_IDLE]) state_next = GRANT;
         end
         GRANT: begin
            err_flag_next = 1'b0;
            state_next    = START;
         end
         START: begin
            if (status[STAT_ERROR]) begin
               state_next    = FIN;
               err_flag_next = 1'b1;
            end else if (status[STAT_BUSY]) begin
               state_next = XFER;
            end else if (tmo_reg) begin
               state_next    = FIN;
               err_flag_next = 1'b1;
            end
         end
         XFER: begin
            if (status[STAT_ERROR]) begin
               state_next    = FIN;
               err_flag_next = 1'b1;
            end else if (status[STAT_DONE]) begin
               state_next    = FIN;
               err_flag_next = 1'b0;
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, captured client, byte and timeout counter; reset aborts silently
   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         err_flag_reg <= 1'b0;
         cur_id_reg   <= 3'd0;
         ptr_reg      <= 3'd0;
         mask_reg     <= '0;
         tx_data_reg  <= '0;
         cnt_reg      <= '0;
         tmo_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         err_flag_reg <= err_flag_next;
         if (state_reg == IDLE && state_next == GRANT) begin
            cur_id_reg <= arb_index;
            mask_reg   <= arb_onehot;
         end
         if (state_reg == GRANT) begin
            tx_data_reg <= slot[cur_id_reg];
            ptr_reg     <= ptr_next;
         end
         if (state_reg == START) begin
            if (cnt_reg != CNT_LAST) cnt_reg <= cnt_reg + 1'b1;
         end else if (state_reg == FIN) begin
            cnt_reg <= '0;
         end
         // Terminal count is registered so the compare stays off the FSM path
         tmo_reg <= (state_reg == START) && (cnt_reg == CNT_LAST);
      end
   end

   // Per-client pulses decoded from the captured one-hot grant
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_pulse
         assign gnt[gi]  = (state_reg == GRANT) && mask_reg[gi];
         assign done[gi] = (state_reg == FIN) && !err_flag_reg && mask_reg[gi];
         assign err[gi]  = (state_reg == FIN) && err_flag_reg && mask_reg[gi];
      end
   endgenerate

   assign tx_data    = tx_data_reg;
   assign tx_rdy     = (state_reg == START);
   assign cur_id     = cur_id_reg;
   assign sched_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a grant/data scoreboard.
module tb_uart_tx_sched;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int TMO  = 32;

   logic               clka;
   logic               reset;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt, done, err;
   logic [DW-1:0]      tx_data;
   logic               tx_rdy, tx_busy, tx_done, tx_error, tx_idle;
   logic [2:0]         cur_id;
   logic               sched_busy;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   logic [NREQ-1:0] exp_gnt_q[$];
   logic [DW-1:0]   exp_data_q[$];
   logic [NREQ-1:0] cur_gnt;

   uart_tx_sched #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
      .clka       (clka),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .done       (done),
      .err        (err),
      .tx_data    (tx_data),
      .tx_rdy     (tx_rdy),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .tx_idle    (tx_idle),
      .cur_id     (cur_id),
      .sched_busy (sched_busy)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [NREQ-1:0] g, input logic [DW-1:0] d);
      exp_gnt_q.push_back(g);
      exp_data_q.push_back(d);
   endtask

   // Wait (bounded) for a grant pulse and compare it with the scoreboard head
   task automatic expect_gnt(input string tag, input int bound);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt == '0 && n < bound);
      cur_gnt = (exp_gnt_q.size() != 0) ? exp_gnt_q.pop_front() : '0;
      check(tag, 32'(gnt), 32'(cur_gnt));
   endtask

   // One cycle after the grant: start request with the captured byte
   task automatic expect_start(input string tag);
      logic [DW-1:0] d;
      tick();
      d = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : '0;
      check({tag, "_rdy"}, 32'(tx_rdy), 32'd1);
      check({tag, "_data"}, 32'(tx_data), 32'(d));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      int  n;
      bit  saw;
      reset    = 1'b0;
      req      = '0;
      req_data = '0;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
      tx_error = 1'b0;
      tx_idle  = 1'b1;

      // Reset state
      tick();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_tx_rdy", 32'(tx_rdy), 32'd0);
      check("rst_cur_id", 32'(cur_id), 32'd0);
      check("rst_busy", 32'(sched_busy), 32'd0);
      tick();
      reset = 1'b1;

      // Single byte from client 0
      req      = 4'b0001;
      req_data = {8'h00, 8'h00, 8'h00, 8'hE8};
      push_exp(4'b0001, 8'hE8);
      expect_gnt("t1_gnt", 1);
      check("t1_cur_id", 32'(cur_id), 32'd0);
      check("t1_sched_busy", 32'(sched_busy), 32'd1);
      req = '0;
      expect_start("t1");
      tx_busy = 1'b1;
      tick();
      check("t1_rdy_fall", 32'(tx_rdy), 32'd0);
      check("t1_data_hold", 32'(tx_data), 32'hE8);
      tx_busy = 1'b0;
      tx_done = 1'b1;
      tick();
      check("t1_done", 32'(done), 32'b0001);
      check("t1_no_err", 32'(err), 32'd0);
      tx_done = 1'b0;
      tick();
      check("t1_idle", 32'(sched_busy), 32'd0);
      check("t1_done_pulse", 32'(done), 32'd0);

      // Round robin with every client requesting; pointer restarts at 0
      do_reset();
      req      = 4'b1111;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int i = 0; i < 5; i++) begin
         push_exp(4'(1 << (i % 4)), 8'(8'h10 + (i % 4)));
         expect_gnt($sformatf("rr_gnt%0d", i), 1);
         expect_start($sformatf("rr%0d", i));
         tx_busy = 1'b1;
         tx_idle = 1'b0;
         repeat (9) tick();
         tx_busy = 1'b0;
         tx_done = 1'b1;
         tick();
         check($sformatf("rr_done%0d", i), 32'(done), 32'(cur_gnt));
         tx_done = 1'b0;
         tx_idle = 1'b1;
         tick();
      end
      req = '0;

      // Start timeout for client 1 (pointer now 1)
      req      = 4'b0010;
      req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
      push_exp(4'b0010, 8'hA5);
      expect_gnt("tmo_gnt", 1);
      check("tmo_cur_id", 32'(cur_id), 32'd1);
      req = '0;
      expect_start("tmo");
      n   = 1;
      saw = 1'b0;
      do begin
         tick();
         n++;
         if (done != '0) saw = 1'b1;
      end while (err == '0 && n < 100);
      check("tmo_latency", 32'(n), 32'(TMO + 2));
      check("tmo_err", 32'(err), 32'b0010);
      check("tmo_no_done", 32'(saw), 32'd0);
      tick();
      check("tmo_rdy_low", 32'(tx_rdy), 32'd0);
      check("tmo_idle", 32'(sched_busy), 32'd0);

      // tx_done and tx_error together in XFER: error wins (pointer now 2)
      req      = 4'b0001;
      req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
      push_exp(4'b0001, 8'h3C);
      expect_gnt("dual_gnt", 1);
      req = '0;
      expect_start("dual");
      tx_busy = 1'b1;
      tick();
      tx_busy  = 1'b0;
      tx_done  = 1'b1;
      tx_error = 1'b1;
      tick();
      check("dual_err", 32'(err), 32'b0001);
      check("dual_no_done", 32'(done), 32'd0);
      tx_done  = 1'b0;
      tx_error = 1'b0;
      tick();

      // Transmitter not idle: request must wait
      tx_idle  = 1'b0;
      req      = 4'b0100;
      req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
      saw      = 1'b0;
      repeat (5) begin
         tick();
         if (gnt != '0) saw = 1'b1;
      end
      check("gate_no_gnt", 32'(saw), 32'd0);
      check("gate_idle", 32'(sched_busy), 32'd0);
      push_exp(4'b0100, 8'h5A);
      tx_idle = 1'b1;
      expect_gnt("gate_gnt", 1);
      check("gate_cur_id", 32'(cur_id), 32'd2);
      req = '0;
      expect_start("gate");
      tx_busy = 1'b1;
      tx_idle = 1'b0;
      tick();
      check("gate_xfer_rdy", 32'(tx_rdy), 32'd0);

      // Asynchronous reset in XFER clears outputs with no clock edge
      #2;
      reset = 1'b0;
      #1;
      check("arst_gnt", 32'(gnt), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      check("arst_tx_data", 32'(tx_data), 32'd0);
      check("arst_cur_id", 32'(cur_id), 32'd0);
      check("arst_busy", 32'(sched_busy), 32'd0);
      tx_busy  = 1'b0;
      tx_idle  = 1'b1;
      req      = 4'b1000;
      req_data = {8'hC3, 8'h00, 8'h00, 8'h00};
      #1;
      reset = 1'b1;
      push_exp(4'b1000, 8'hC3);
      expect_gnt("post_rst_gnt", 1);
      check("post_rst_cur_id", 32'(cur_id), 32'd3);
      req = '0;
      expect_start("post_rst");
      tx_busy = 1'b1;
      tick();
      tx_busy = 1'b0;
      tx_done = 1'b1;
      tick();
      check("post_rst_done", 32'(done), 32'b1000);
      tx_done = 1'b0;
      tick();
      check("post_rst_idle", 32'(sched_busy), 32'd0);
      check("sb_empty", 32'(exp_gnt_q.size() + exp_data_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single UART transmitter among NREQ byte-producing clients.
- Sits between client logic and the UART tx port: it drives tx_data/tx_rdy and tracks tx_busy/tx_done/tx_error/tx_idle.
- Returns per-client grant, completion and error pulses.
- Guards against a transmitter that never starts with a start-timeout.

Parameters:
- NREQ, 4, number of requesting clients (2..8)
- DW, 8, data byte width
- TMO, 32, cycles allowed between tx_rdy assertion and tx_busy before abort (≥2)

Ports:
- clka  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req  in  NREQ  per-client request, level, held until gnt
- req_data  in  NREQ*DW  client i byte at bits [i*DW +: DW]
- gnt  out  NREQ  one-hot, 1-cycle pulse: byte of client cur_id captured
- done  out  NREQ  one-hot, 1-cycle pulse: byte sent OK
- err  out  NREQ  one-hot, 1-cycle pulse: tx_error or start timeout
- tx_data  out  DW  byte to UART tx
- tx_rdy  out  1  start request to UART tx
- tx_busy  in  1  UART tx shifting
- tx_done  in  1  UART tx frame complete
- tx_error  in  1  UART tx error
- tx_idle  in  1  UART tx idle
- cur_id  out  3  index of the client being served
- sched_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; gnt/done/err=0; tx_data=0; tx_rdy=0; cur_id=0; sched_busy=0.
  - Round-robin pointer=0; timeout counter=0.
- Reset mid-transfer aborts silently: no done/err pulse is issued.
- States: IDLE, GRANT, START, XFER, FIN.
- IDLE:
  - If (req!=0 && tx_idle): pick the first set req bit scanning from ptr upward, wrapping at NREQ-1→0.
  - Go to GRANT.
  - If tx_idle=0, stay in IDLE.
- GRANT (1 cycle):
  - gnt[cur_id]=1; tx_data<=req_data slice; ptr<=cur_id+1 mod NREQ.
  - Go to START.
  - Client may drop req or change data after this cycle.
- START:
  - tx_rdy=1; counter increments each cycle.
  - tx_busy=1 → XFER, tx_rdy falls on the next cycle.
  - tx_error=1 → FIN with error.
  - counter reaches TMO-1 without tx_busy → FIN with error.
- XFER:
  - tx_rdy=0; tx_data held stable.
  - tx_done=1 → FIN OK.
  - tx_error=1 → FIN error.
  - tx_done and tx_error in the same cycle: error wins.
- FIN (1 cycle):
  - done[cur_id] or err[cur_id] pulses; counter cleared.
  - Go to IDLE.
- Latency: req seen in IDLE → gnt 1 cycle later → tx_rdy 2 cycles later. Minimum turnaround FIN→next GRANT is 2 cycles.
- Fairness: a client granted last has lowest priority next. With all req high, the grant order is 0,1,2,3,0...
- Arbitration uses the req value sampled in IDLE only. A req rising during service waits its turn.
- cur_id is valid from GRANT through FIN and holds its value in IDLE.
- cur_id upper bits are 0 when NREQ<8.
- sched_busy is high in GRANT, START, XFER and FIN.
- Counter width is clog2(TMO)+1; it never wraps, saturating at TMO-1.

Decomposition:
- Shared package uart_pkg:
  - state encoding typedef (IDLE=0, GRANT=1, START=2, XFER=3, FIN=4)
  - DW default
  - UART status bit positions
- One sub-module: rr_arbiter (NREQ one-hot round-robin picker).
  - Inputs: req, ptr. Outputs: onehot, index, valid.
  - Purely combinational; the FSM stays in uart_tx_sched.

Test Plan:
- Reset, then req=4'b0001, req_data[7:0]=8'hE8, tx_idle=1 → gnt=0001 one cycle later, tx_data=E8, tx_rdy=1 the next cycle. Drive tx_busy → tx_rdy=0; drive tx_done → done=0001 pulse, state IDLE.
- req=4'b1111 held, model UART finishing each byte in 10 cycles → gnt sequence 0001,0010,0100,1000,0001; no client starved.
- req=4'b0010, tx_busy never asserted → err=0010 pulse exactly TMO+2 cycles after gnt; tx_rdy low afterwards; no done.
- In XFER, assert tx_done and tx_error together → err pulse only, done stays 0.
- tx_idle=0 with req=4'b0100 → no gnt. Raise tx_idle → gnt=0100 next cycle.
- Assert reset=0 during XFER → all outputs 0 immediately without a clock edge. After release with req=4'b1000, the next gnt is 1000 with ptr starting from 0.
